// File: rtl/id_ex_pipe_if.sv
// Instruction bundle carried between pipeline stages. The ID stage drives it
// through master and the ID/EX register reads it through slave.
interface id_ex_pipe_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              RegDst;
    logic              Jump;
    logic              Branch;
    logic              MemRead;
    logic              MemtoReg;
    logic              MemWrite;
    logic              ALUSrc1;
    logic              ALUSrc2;
    logic              RegWrite;
    logic              JALorJALR;
    logic [6:0]        ALUOp;
    logic [3:0]        BE;
    logic [2:0]        Concat_control;

    modport master (
        output valid, opcode, funct3, funct7b5, rs1, rs2, rd,
        output pc, rs1_data, rs2_data, imm,
        output RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite,
        output ALUSrc1, ALUSrc2, RegWrite, JALorJALR,
        output ALUOp, BE, Concat_control
    );

    modport slave (
        input valid, opcode, funct3, funct7b5, rs1, rs2, rd,
        input pc, rs1_data, rs2_data, imm,
        input RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite,
        input ALUSrc1, ALUSrc2, RegWrite, JALorJALR,
        input ALUOp, BE, Concat_control
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush, hold,
// illegal-opcode squash and saturating stall/flush event counters.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    id_ex_pipe_if.slave      id,
    id_ex_pipe_if.master     ex,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,
    output logic             illegal_inst,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic              RegDst;
        logic              Jump;
        logic              Branch;
        logic              MemRead;
        logic              MemtoReg;
        logic              MemWrite;
        logic              ALUSrc1;
        logic              ALUSrc2;
        logic              RegWrite;
        logic              JALorJALR;
        logic [6:0]        ALUOp;
        logic [3:0]        BE;
        logic [2:0]        Concat_control;
    } bundle_t;

    bundle_t q;
    bundle_t nxt;
    logic    legal;
    logic    uses_rs1;
    logic    uses_rs2;
    logic    hazard;

    always_comb begin
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (id.opcode)
            7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: begin
                legal    = 1'b0;
                uses_rs1 = 1'b0;
            end
        endcase
    end

    assign hazard = q.valid && q.MemRead && (q.rd != 5'd0) && id.valid &&
                    ((uses_rs1 && (id.rs1 == q.rd)) ||
                     (uses_rs2 && (id.rs2 == q.rd)));

    assign stall = ex_hold | (hazard & ~flush);

    always_comb begin
        nxt.valid          = id.valid;
        nxt.opcode         = id.opcode;
        nxt.funct3         = id.funct3;
        nxt.funct7b5       = id.funct7b5;
        nxt.rs1            = id.rs1;
        nxt.rs2            = id.rs2;
        nxt.rd             = id.rd;
        nxt.pc             = id.pc;
        nxt.rs1_data       = id.rs1_data;
        nxt.rs2_data       = id.rs2_data;
        nxt.imm            = id.imm;
        nxt.RegDst         = id.RegDst;
        nxt.Jump           = id.Jump;
        nxt.Branch         = id.Branch;
        nxt.MemRead        = id.MemRead;
        nxt.MemtoReg       = id.MemtoReg;
        nxt.MemWrite       = id.MemWrite;
        nxt.ALUSrc1        = id.ALUSrc1;
        nxt.ALUSrc2        = id.ALUSrc2;
        nxt.RegWrite       = id.RegWrite;
        nxt.JALorJALR      = id.JALorJALR;
        nxt.ALUOp          = id.ALUOp;
        nxt.BE             = id.BE;
        nxt.Concat_control = id.Concat_control;
        // An empty ID slot must never commit state downstream.
        if (!id.valid) begin
            nxt.RegWrite = 1'b0;
            nxt.MemWrite = 1'b0;
            nxt.MemRead  = 1'b0;
            nxt.Branch   = 1'b0;
            nxt.Jump     = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q            <= '0;
            illegal_inst <= 1'b0;
            load_use_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            illegal_inst <= 1'b0;
            if (!ex_hold) begin
                if (flush) begin
                    q <= '0;
                    if (id.valid && (flush_cnt != '1))
                        flush_cnt <= flush_cnt + 1'b1;
                end else if (hazard) begin
                    q <= '0;
                    if (load_use_cnt != '1)
                        load_use_cnt <= load_use_cnt + 1'b1;
                end else if (id.valid && !legal) begin
                    q            <= '0;
                    illegal_inst <= 1'b1;
                end else begin
                    q <= nxt;
                end
            end
        end
    end

    assign ex.valid          = q.valid;
    assign ex.opcode         = q.opcode;
    assign ex.funct3         = q.funct3;
    assign ex.funct7b5       = q.funct7b5;
    assign ex.rs1            = q.rs1;
    assign ex.rs2            = q.rs2;
    assign ex.rd             = q.rd;
    assign ex.pc             = q.pc;
    assign ex.rs1_data       = q.rs1_data;
    assign ex.rs2_data       = q.rs2_data;
    assign ex.imm            = q.imm;
    assign ex.RegDst         = q.RegDst;
    assign ex.Jump           = q.Jump;
    assign ex.Branch         = q.Branch;
    assign ex.MemRead        = q.MemRead;
    assign ex.MemtoReg       = q.MemtoReg;
    assign ex.MemWrite       = q.MemWrite;
    assign ex.ALUSrc1        = q.ALUSrc1;
    assign ex.ALUSrc2        = q.ALUSrc2;
    assign ex.RegWrite       = q.RegWrite;
    assign ex.JALorJALR      = q.JALorJALR;
    assign ex.ALUOp          = q.ALUOp;
    assign ex.BE             = q.BE;
    assign ex.Concat_control = q.Concat_control;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: capture, load-use, flush, hold, illegal
// squash, counter saturation and asynchronous reset.
module tb_id_ex_pipe;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic             CLK = 1'b0;
    logic             RST;
    logic             flush;
    logic             ex_hold;
    logic             stall;
    logic             illegal_inst;
    logic [CNT_W-1:0] load_use_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_pipe_if #(.DATA_W(DATA_W)) id_if ();
    id_ex_pipe_if #(.DATA_W(DATA_W)) ex_if ();

    id_ex_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id           (id_if),
        .ex           (ex_if),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .stall        (stall),
        .illegal_inst (illegal_inst),
        .load_use_cnt (load_use_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic mr,
                         input logic [31:0] pc);
        id_if.valid          = v;
        id_if.opcode         = op;
        id_if.funct3         = rd[2:0];
        id_if.funct7b5       = r1[0];
        id_if.rs1            = r1;
        id_if.rs2            = r2;
        id_if.rd             = rd;
        id_if.pc             = pc;
        id_if.rs1_data       = pc ^ 32'hA5A5_0000;
        id_if.rs2_data       = pc + 32'd1;
        id_if.imm            = pc + 32'd4;
        id_if.RegDst         = 1'b1;
        id_if.Jump           = (op == OP_JAL);
        id_if.Branch         = 1'b0;
        id_if.MemRead        = mr;
        id_if.MemtoReg       = mr;
        id_if.MemWrite       = (op == OP_SW);
        id_if.ALUSrc1        = 1'b0;
        id_if.ALUSrc2        = 1'b1;
        id_if.RegWrite       = 1'b1;
        id_if.JALorJALR      = 1'b0;
        id_if.ALUOp          = op;
        id_if.BE             = 4'hF;
        id_if.Concat_control = 3'b101;
    endtask

    task automatic do_reset();
        flush   = 1'b0;
        ex_hold = 1'b0;
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ex_hold = 1'b0;
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b0 || ex_if.pc !== 32'd0 || ex_if.RegWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ex: valid=%b pc=%h rw=%b want 0", ex_if.valid, ex_if.pc, ex_if.RegWrite);
        end
        n_cmp++;
        if (illegal_inst !== 1'b0 || load_use_cnt !== '0 || flush_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_misc: ill=%b lu=%0d fl=%0d want 0", illegal_inst, load_use_cnt, flush_cnt);
        end
        ex_hold = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_stall_hold: got %b want 1", stall);
        end
        ex_hold = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        RST = 1'b0;
    endtask

    task automatic test_capture();
        do_reset();
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'h100);
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b1 || ex_if.pc !== 32'h100 || ex_if.rd !== 5'd3 ||
            ex_if.RegWrite !== 1'b1 || ex_if.imm !== 32'h104 ||
            ex_if.rs1_data !== 32'hA5A5_0100 || ex_if.ALUOp !== OP_ADD) begin
            n_bad++;
            $display("FAIL capture: valid=%b pc=%h rd=%0d rw=%b imm=%h r1d=%h want 1 100 3 1 104 a5a50100",
                     ex_if.valid, ex_if.pc, ex_if.rd, ex_if.RegWrite, ex_if.imm, ex_if.rs1_data);
        end
        drive(1'b0, OP_SW, 5'd1, 5'd2, 5'd3, 1'b1, 32'h200);
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b0 || ex_if.RegWrite !== 1'b0 || ex_if.MemWrite !== 1'b0 ||
            ex_if.MemRead !== 1'b0 || ex_if.pc !== 32'h200) begin
            n_bad++;
            $display("FAIL capture_invalid: valid=%b rw=%b mw=%b mr=%b pc=%h want 0 0 0 0 200",
                     ex_if.valid, ex_if.RegWrite, ex_if.MemWrite, ex_if.MemRead, ex_if.pc);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'h300);
        tick();
        drive(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6, 1'b0, 32'h304);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want 1", stall);
        end
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b0 || ex_if.RegWrite !== 1'b0 || load_use_cnt !== 4'd1 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_bubble: valid=%b rw=%b cnt=%0d stall=%b want 0 0 1 0",
                     ex_if.valid, ex_if.RegWrite, load_use_cnt, stall);
        end
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b1 || ex_if.rd !== 5'd6 || ex_if.pc !== 32'h304) begin
            n_bad++;
            $display("FAIL lu_capture: valid=%b rd=%0d pc=%h want 1 6 304", ex_if.valid, ex_if.rd, ex_if.pc);
        end
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'h400);
        tick();
        drive(1'b1, OP_LUI, 5'd5, 5'd5, 5'd8, 1'b0, 32'h404);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL nfh_lui: got %b want 0", stall);
        end
        drive(1'b1, OP_JAL, 5'd5, 5'd5, 5'd1, 1'b0, 32'h404);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL nfh_jal: got %b want 0", stall);
        end
        drive(1'b1, OP_SW, 5'd2, 5'd5, 5'd0, 1'b0, 32'h404);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL haz_sw_rs2: got %b want 1", stall);
        end
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b1, 32'h500);
        tick();
        drive(1'b1, OP_ADD, 5'd0, 5'd0, 5'd9, 1'b0, 32'h504);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL nfh_x0: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b1 || ex_if.pc !== 32'h504 || load_use_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL nfh_x0_capture: valid=%b pc=%h cnt=%0d want 1 504 0", ex_if.valid, ex_if.pc, load_use_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'h600);
        tick();
        drive(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6, 1'b0, 32'h604);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b0 || ex_if.RegWrite !== 1'b0 || ex_if.pc !== 32'd0 ||
            flush_cnt !== 4'd1 || load_use_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL flush_bubble: valid=%b rw=%b pc=%h fl=%0d lu=%0d want 0 0 0 1 0",
                     ex_if.valid, ex_if.RegWrite, ex_if.pc, flush_cnt, load_use_cnt);
        end
        drive(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'h608);
        tick();
        flush = 1'b0;
        n_cmp++;
        if (flush_cnt !== 4'd1 || ex_if.pc !== 32'd0) begin
            n_bad++;
            $display("FAIL flush_invalid: fl=%0d pc=%h want 1 0", flush_cnt, ex_if.pc);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'h700);
        tick();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6, 1'b0, 32'h710 + 32'(i * 4));
            flush = (i == 1);
            #1;
            n_cmp++;
            if (stall !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_stall[%0d]: got %b want 1", i, stall);
            end
            tick();
            n_cmp++;
            if (ex_if.pc !== 32'h700 || ex_if.MemRead !== 1'b1 || ex_if.valid !== 1'b1 ||
                load_use_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
                n_bad++;
                $display("FAIL hold_keep[%0d]: pc=%h mr=%b v=%b lu=%0d fl=%0d want 700 1 1 0 0",
                         i, ex_if.pc, ex_if.MemRead, ex_if.valid, load_use_cnt, flush_cnt);
            end
        end
        ex_hold = 1'b0;
        flush   = 1'b0;
        drive(1'b1, OP_LUI, 5'd0, 5'd0, 5'd9, 1'b0, 32'h800);
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b1 || ex_if.pc !== 32'h800 || ex_if.rd !== 5'd9) begin
            n_bad++;
            $display("FAIL hold_release: valid=%b pc=%h rd=%0d want 1 800 9", ex_if.valid, ex_if.pc, ex_if.rd);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd3, 1'b0, 32'h900);
        id_if.RegWrite = 1'bx;
        id_if.MemWrite = 1'bx;
        id_if.MemRead  = 1'bx;
        id_if.ALUOp    = 'x;
        id_if.BE       = 'x;
        id_if.imm      = 'x;
        tick();
        n_cmp++;
        if (illegal_inst !== 1'b1 || ex_if.valid !== 1'b0 || ex_if.RegWrite !== 1'b0 ||
            ex_if.MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_squash: ill=%b valid=%b rw=%b mw=%b want 1 0 0 0",
                     illegal_inst, ex_if.valid, ex_if.RegWrite, ex_if.MemWrite);
        end
        n_cmp++;
        if (ex_if.imm !== 32'd0 || ex_if.ALUOp !== 7'd0 || ex_if.BE !== 4'd0 ||
            ex_if.pc !== 32'd0 || ex_if.opcode !== 7'd0 || ex_if.MemRead !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_zero: imm=%h aluop=%h be=%h pc=%h op=%h want all 0",
                     ex_if.imm, ex_if.ALUOp, ex_if.BE, ex_if.pc, ex_if.opcode);
        end
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'h904);
        tick();
        n_cmp++;
        if (illegal_inst !== 1'b0 || ex_if.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_pulse: ill=%b valid=%b want 0 1", illegal_inst, ex_if.valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'hA00);
            tick();
            drive(1'b1, OP_ADD, 5'd5, 5'd7, 5'd6, 1'b0, 32'hA04);
            tick();
        end
        n_cmp++;
        if (load_use_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL lu_saturate: got %0d want 15", load_use_cnt);
        end
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd4, 1'b0, 32'hB00);
        tick();
        #3;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (ex_if.valid !== 1'b0 || ex_if.pc !== 32'd0 || ex_if.RegWrite !== 1'b0 ||
            load_use_cnt !== 4'd0 || flush_cnt !== 4'd0 || illegal_inst !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b pc=%h rw=%b lu=%0d fl=%0d want 0 0 0 0 0",
                     ex_if.valid, ex_if.pc, ex_if.RegWrite, load_use_cnt, flush_cnt);
        end
        #1;
        RST = 1'b0;
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd4, 1'b0, 32'hC00);
        tick();
        n_cmp++;
        if (ex_if.valid !== 1'b1 || ex_if.pc !== 32'hC00) begin
            n_bad++;
            $display("FAIL post_reset_capture: valid=%b pc=%h want 1 c00", ex_if.valid, ex_if.pc);
        end
    endtask

    initial begin
        RST     = 1'b1;
        flush   = 1'b0;
        ex_hold = 1'b0;
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        tick();
        test_reset();
        test_capture();
        test_load_use();
        test_no_false_hazard();
        test_flush();
        test_hold();
        test_illegal();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the five-stage RISC-V pipeline CPU. It captures the decoded control bundle from the ID-stage control decoder, plus the ID operand/immediate/index fields, and presents them to EX one cycle later. It contains the load-use hazard detector, bubble insertion, branch/jump flush, downstream hold and illegal-opcode squash. Two saturating performance counters record stall and flush events.

## Interface
- DATA_W, 32, width of PC, register operands and immediate
- CNT_W, 16, width of each saturating performance counter
- CLK  in  1  pipeline clock; all state changes on rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  opcode of ID instruction
- id_funct3  in  3  funct3 of ID instruction
- id_funct7b5  in  1  instruction bit 30
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  DATA_W each  ID data fields
- id_RegDst, id_Jump, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_JALorJALR  in  1 each  decoder control bits
- id_ALUOp  in  7;  id_BE  in  4;  id_Concat_control  in  3  decoder control fields
- flush  in  1  level; EX resolved a taken branch/jump; ID instruction is wrong-path
- ex_hold  in  1  level; a later stage cannot accept; EX must hold
- stall  out  1  combinational; IF/ID and PC must hold this cycle
- illegal_inst  out  1  registered one-cycle pulse; an illegal opcode was squashed
- ex_valid  out  1  EX holds a real instruction
- ex_* outputs  out  same widths as id_* counterparts  registered copies of every id_* field above, except id_valid (reflected as ex_valid)
- load_use_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Legal opcodes: 0110111, 0010111, 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111. Any other opcode is illegal.
- uses_rs1: every legal opcode except 0110111, 0010111 and 1101111.
- uses_rs2: opcodes 0110011, 0100011 and 1100011 only.
- hazard = ex_valid & ex_MemRead & ex_rd!=0 & id_valid & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- stall = ex_hold | (hazard & ~flush).
- Per-edge action, in priority order:
  - RST: clear.
  - ex_hold: hold all registers.
  - flush: load bubble.
  - hazard: load bubble.
  - id_valid & illegal opcode: load bubble and set illegal_inst.
  - Otherwise: capture all id_* fields, with ex_valid=id_valid.
- Bubble: ex_valid=0 and ex_RegWrite=ex_MemWrite=ex_MemRead=ex_Branch=ex_Jump=0. All other ex_* fields are 0, so no X from decoder don't-cares ever reaches EX.
- When id_valid=0, the captured safety bits are forced to 0, as for a bubble.
- illegal_inst is 1 only in the cycle after the squashing edge; otherwise 0.
- load_use_cnt increments on each edge where a bubble is loaded due to hazard.
- flush_cnt increments on each edge where a bubble is loaded due to flush with id_valid=1.
- Neither counter increments while ex_hold=1. Both saturate at all-ones.

## Timing
- Latency ID→EX: 1 cycle. stall has zero latency (combinational from id_* and registered ex_*).
- Reset values: every ex_* output, ex_valid, illegal_inst, load_use_cnt and flush_cnt are 0. stall follows ex_hold during reset.
- Asynchronous reset mid-operation clears EX contents immediately, with no waiting for the clock. The first edge after deassertion performs a normal capture.
- A load-use stall lasts exactly 1 cycle when ex_hold=0. The next cycle EX holds a bubble, so hazard deasserts.
- flush and hazard in the same cycle: flush wins, stall=0, flush_cnt increments, load_use_cnt does not.
- ex_hold with flush: hold wins. The flush source keeps flush asserted until ex_hold drops.
- ex_rd=0 never creates a hazard. A load into x0 followed by a read of x0 proceeds without a stall.

## Test plan
- Load-use: ex holds LW x5 (ex_MemRead=1, ex_rd=5); ID drives ADD x6,x5,x7 (opcode 0110011, rs1=5). Required: stall=1 for one cycle. Next cycle ex_valid=0 and ex_RegWrite=0. The ADD is captured on the following edge. load_use_cnt=1.
- No false hazard: LW x5 in EX; ID drives LUI x5 or JAL with rs1 field=5. Required: stall=0. x0 case: LW x0 in EX, ADD reads x0. Required: stall=0.
- Flush: taken branch with flush=1 and ID instruction valid, hazard also true. Required: bubble loaded, stall=0, flush_cnt=1, load_use_cnt=0.
- Hold: ex_hold=1 for 3 cycles while ID changes each cycle. Required: ex_* stays constant, stall=1, both counters unchanged. After ex_hold drops, the current ID instruction is captured.
- Illegal: id_opcode=1111111, id_valid=1, decoder outputs X. Required next cycle: illegal_inst=1 for exactly one cycle, ex_valid=0, ex_RegWrite=ex_MemWrite=0, no X on any ex_* output.
- Reset/saturation: preload CNT_W=4, force 20 hazards. Required: load_use_cnt=15. Assert RST asynchronously between edges. Required: all outputs 0 before the next edge.
